// File: rtl/execute_stage.sv
// Execute stage: 16x32 register file, NZCV flags, 32-word data RAM
// with one GPIO word at address 32, and taken-branch redirect to Fetch.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   num_to_rhs, num    right-operand select and immediate/offset/delta
//   sel_p0, sel_p1     operand A / B register indices
//   sel_in             destination register index
//   uop                micro-op code (12..31 act as NOP)
//   branch_cond        ARM condition, 4'b1111 = not a branch
//   global_disable     one-cycle squash pulse after a taken branch
//   delta_instruction  branch offset while global_disable is high
//   gpio_state         current GPIO register value
module execute_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        num_to_rhs,
  input  logic [31:0] num,
  input  logic [3:0]  sel_p0,
  input  logic [3:0]  sel_p1,
  input  logic [3:0]  sel_in,
  input  logic [4:0]  uop,
  input  logic [3:0]  branch_cond,
  output logic        global_disable,
  output logic [31:0] delta_instruction,
  output logic [31:0] gpio_state
);

  localparam logic [4:0] UOP_NOP = 5'd0;
  localparam logic [4:0] UOP_ADD = 5'd1;
  localparam logic [4:0] UOP_SUB = 5'd2;
  localparam logic [4:0] UOP_AND = 5'd3;
  localparam logic [4:0] UOP_EOR = 5'd4;
  localparam logic [4:0] UOP_CMP = 5'd5;
  localparam logic [4:0] UOP_LSL = 5'd6;
  localparam logic [4:0] UOP_LSR = 5'd7;
  localparam logic [4:0] UOP_MOV = 5'd8;
  localparam logic [4:0] UOP_STR = 5'd9;
  localparam logic [4:0] UOP_LDR = 5'd10;
  localparam logic [4:0] UOP_ORR = 5'd11;

  logic [31:0] rf  [16];
  logic [31:0] ram [32];
  logic [31:0] gpio;
  logic        f_n, f_z, f_c, f_v;

  logic [31:0] op_a, op_b, op_r;
  logic [4:0]  shamt;
  logic [32:0] diff;
  logic [31:0] addr, ld_data, alu_res;
  logic        addr_ram, addr_gpio;
  logic        is_branch, cond_ok, live, taken, exec;
  logic        rf_we, flag_we, ram_we, gpio_we;

  assign gpio_state = gpio;

  always_comb begin
    op_a      = rf[sel_p0];
    op_b      = rf[sel_p1];
    op_r      = num_to_rhs ? num : op_b;
    shamt     = num_to_rhs ? num[4:0] : op_a[4:0];
    // 33-bit subtract: bit 32 is the borrow
    diff      = {1'b0, op_a} - {1'b0, op_r};
    addr      = op_b + op_r;
    addr_ram  = (addr[31:5] == 27'd0);
    addr_gpio = (addr == 32'd32);
    if (addr_ram)
      ld_data = ram[addr[4:0]];
    else if (addr_gpio)
      ld_data = gpio;
    else
      ld_data = '0;
  end

  always_comb begin
    cond_ok = 1'b0;
    unique case (branch_cond)
      4'h0: cond_ok = f_z;
      4'h1: cond_ok = !f_z;
      4'h2: cond_ok = f_c;
      4'h3: cond_ok = !f_c;
      4'h4: cond_ok = f_n;
      4'h5: cond_ok = !f_n;
      4'h6: cond_ok = f_v;
      4'h7: cond_ok = !f_v;
      4'h8: cond_ok = f_c && !f_z;
      4'h9: cond_ok = !f_c || f_z;
      4'ha: cond_ok = (f_n == f_v);
      4'hb: cond_ok = (f_n != f_v);
      4'hc: cond_ok = !f_z && (f_n == f_v);
      4'hd: cond_ok = f_z || (f_n != f_v);
      4'he: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // the cycle after a taken branch is squashed, branches included
  assign is_branch = (branch_cond != 4'hf);
  assign live      = !global_disable;
  assign taken     = live && is_branch && cond_ok;
  assign exec      = live && !is_branch;

  always_comb begin
    alu_res = '0;
    rf_we   = 1'b0;
    flag_we = 1'b0;
    ram_we  = 1'b0;
    gpio_we = 1'b0;
    unique case (uop)
      UOP_NOP: ;
      UOP_ADD: begin alu_res = op_a + op_r;     rf_we = exec; end
      UOP_SUB: begin alu_res = diff[31:0];      rf_we = exec; end
      UOP_AND: begin alu_res = op_a & op_r;     rf_we = exec; end
      UOP_EOR: begin alu_res = op_a ^ op_r;     rf_we = exec; end
      UOP_CMP: flag_we = exec;
      UOP_LSL: begin alu_res = op_b << shamt;   rf_we = exec; end
      UOP_LSR: begin alu_res = op_b >> shamt;   rf_we = exec; end
      UOP_MOV: begin
        alu_res = num_to_rhs ? num : op_a;
        rf_we   = exec;
      end
      UOP_STR: begin
        ram_we  = exec && addr_ram;
        gpio_we = exec && addr_gpio;
      end
      UOP_LDR: begin alu_res = ld_data;         rf_we = exec; end
      UOP_ORR: begin alu_res = op_a | op_r;     rf_we = exec; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
      f_n               <= 1'b0;
      f_z               <= 1'b0;
      f_c               <= 1'b0;
      f_v               <= 1'b0;
      gpio              <= '0;
      global_disable    <= 1'b0;
      delta_instruction <= '0;
    end else begin
      if (rf_we) rf[sel_in] <= alu_res;
      if (flag_we) begin
        f_n <= diff[31];
        f_z <= (diff[31:0] == 32'd0);
        f_c <= !diff[32];
        f_v <= (op_a[31] ^ op_r[31]) & (op_a[31] ^ diff[31]);
      end
      if (gpio_we) gpio <= op_a;
      global_disable    <= taken;
      delta_instruction <= taken ? num : '0;
    end
  end

  // RAM contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) ram[addr[4:0]] <= op_a;
  end

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed program plus random instruction
// stream checked against a behavioural model of the stage.
module tb_execute_stage;

  logic        clk;
  logic        rst_n;
  logic        num_to_rhs;
  logic [31:0] num;
  logic [3:0]  sel_p0, sel_p1, sel_in;
  logic [4:0]  uop;
  logic [3:0]  branch_cond;
  logic        global_disable;
  logic [31:0] delta_instruction;
  logic [31:0] gpio_state;

  execute_stage dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .num_to_rhs        (num_to_rhs),
    .num               (num),
    .sel_p0            (sel_p0),
    .sel_p1            (sel_p1),
    .sel_in            (sel_in),
    .uop               (uop),
    .branch_cond       (branch_cond),
    .global_disable    (global_disable),
    .delta_instruction (delta_instruction),
    .gpio_state        (gpio_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_rf  [16];
  logic [31:0] m_mem [32];
  logic [31:0] m_gpio;
  logic [31:0] m_delta;
  bit          m_gd;
  bit          m_n, m_z, m_c, m_v;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic bit cond_ok(input logic [3:0] c);
    case (c)
      4'h0: return m_z;
      4'h1: return !m_z;
      4'h2: return m_c;
      4'h3: return !m_c;
      4'h4: return m_n;
      4'h5: return !m_n;
      4'h6: return m_v;
      4'h7: return !m_v;
      4'h8: return m_c && !m_z;
      4'h9: return !m_c || m_z;
      4'ha: return m_n == m_v;
      4'hb: return m_n != m_v;
      4'hc: return !m_z && (m_n == m_v);
      4'hd: return m_z || (m_n != m_v);
      4'he: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    m_gpio = '0; m_delta = '0; m_gd = 0;
    m_n = 0; m_z = 0; m_c = 0; m_v = 0;
  endtask

  task automatic step(input bit ntr, input logic [31:0] n,
                      input logic [3:0] p0, input logic [3:0] p1,
                      input logic [3:0] d, input logic [4:0] op,
                      input logic [3:0] bc);
    logic [31:0] a, b, r, ad, res;
    int          s;
    longint      sd;
    bit          live;
    num_to_rhs = ntr; num = n; sel_p0 = p0; sel_p1 = p1;
    sel_in = d; uop = op; branch_cond = bc;
    a  = m_rf[p0];
    b  = m_rf[p1];
    r  = ntr ? n : b;
    s  = ntr ? int'(n[4:0]) : int'(a[4:0]);
    ad = b + r;
    live = !m_gd;
    m_gd = 0;
    m_delta = '0;
    if (live && bc != 4'hf) begin
      if (cond_ok(bc)) begin
        m_gd = 1;
        m_delta = n;
      end
    end else if (live) begin
      case (op)
        5'd1:  m_rf[d] = a + r;
        5'd2:  m_rf[d] = a - r;
        5'd3:  m_rf[d] = a & r;
        5'd4:  m_rf[d] = a ^ r;
        5'd5: begin
          res = a - r;
          sd  = longint'($signed(a)) - longint'($signed(r));
          m_n = res[31];
          m_z = (res == 0);
          m_c = (a >= r);
          m_v = (sd != longint'($signed(res)));
        end
        5'd6:  m_rf[d] = b << s;
        5'd7:  m_rf[d] = b >> s;
        5'd8:  m_rf[d] = ntr ? n : a;
        5'd9: begin
          if (ad < 32) m_mem[ad[4:0]] = a;
          else if (ad == 32) m_gpio = a;
        end
        5'd10: begin
          if (ad < 32) m_rf[d] = m_mem[ad[4:0]];
          else if (ad == 32) m_rf[d] = m_gpio;
          else m_rf[d] = '0;
        end
        5'd11: m_rf[d] = a | r;
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    check("global_disable", {31'd0, global_disable}, {31'd0, m_gd});
    check("delta_instruction", delta_instruction, m_delta);
    check("gpio_state", gpio_state, m_gpio);
  endtask

  // copy a register to GPIO through STR [r0 + (32 - r0)]
  task automatic peek(input logic [3:0] k);
    step(1, 32'd32 - m_rf[0], k, 4'd0, 4'd0, 5'd9, 4'hf);
  endtask

  task automatic mov_i(input logic [3:0] d, input logic [31:0] v);
    step(1, v, 4'd0, 4'd0, d, 5'd8, 4'hf);
  endtask

  initial begin
    logic [31:0] n;
    logic [4:0]  op;
    logic [3:0]  bc, p0, p1, d;
    bit          ntr;

    model_reset();
    rst_n = 1'b0;
    num_to_rhs = 0; num = '0; sel_p0 = '0; sel_p1 = '0;
    sel_in = '0; uop = '0; branch_cond = 4'hf;
    #3;
    check("reset_gd", {31'd0, global_disable}, 32'd0);
    check("reset_delta", delta_instruction, 32'd0);
    check("reset_gpio", gpio_state, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // fill RAM with known data (RAM is not reset)
    for (int i = 0; i < 32; i++) begin
      mov_i(4'd1, $urandom);
      step(1, i, 4'd1, 4'd0, 4'd0, 5'd9, 4'hf);
    end

    // directed program
    mov_i(4'd1, 32'hcafe);
    mov_i(4'd2, 32'hdead);
    step(0, 32'd0, 4'd2, 4'd0, 4'd3, 5'd8, 4'hf);
    step(0, 32'd0, 4'd1, 4'd2, 4'd4, 5'd1, 4'hf);
    peek(4'd3); check("mov_reg_r3", gpio_state, 32'hdead);
    peek(4'd4); check("add_r4", gpio_state, 32'h1a9ab);
    step(0, 32'd0, 4'd2, 4'd4, 4'd2, 5'd3, 4'hf);
    step(0, 32'd0, 4'd1, 4'd3, 4'd1, 5'd4, 4'hf);
    peek(4'd2); check("and_r2", gpio_state, 32'h88a9);
    peek(4'd1); check("eor_r1", gpio_state, 32'h1453);

    mov_i(4'd6, 32'd1);
    mov_i(4'd7, 32'd1);
    step(0, 32'd0, 4'd6, 4'd7, 4'd6, 5'd5, 4'hf);
    step(0, 32'd5, 4'd0, 4'd0, 4'd0, 5'd0, 4'h0);
    check("beq_taken", {31'd0, global_disable}, 32'd1);
    mov_i(4'd6, 32'd99);
    check("squash_clears", {31'd0, global_disable}, 32'd0);
    peek(4'd6); check("squashed_mov", gpio_state, 32'd1);
    step(0, 32'd3, 4'd0, 4'd0, 4'd0, 5'd0, 4'h4);
    check("bmi_not_taken", {31'd0, global_disable}, 32'd0);
    step(0, 32'd3, 4'd0, 4'd0, 4'd0, 5'd0, 4'h6);
    check("bvs_not_taken", {31'd0, global_disable}, 32'd0);

    mov_i(4'd1, 32'hcafe);
    step(0, 32'd0, 4'd1, 4'd7, 4'd14, 5'd1, 4'hf);
    step(1, 32'd31, 4'd14, 4'd6, 4'd0, 5'd9, 4'hf);
    check("str_gpio", gpio_state, 32'hcaff);
    step(1, 32'd31, 4'd0, 4'd6, 4'd8, 5'd10, 4'hf);
    mov_i(4'd8, 32'd0);
    step(1, 32'd31, 4'd0, 4'd6, 4'd8, 5'd10, 4'hf);

    step(0, 32'd10, 4'd0, 4'd0, 4'd0, 5'd0, 4'he);
    check("bal_gd", {31'd0, global_disable}, 32'd1);
    check("bal_delta", delta_instruction, 32'd10);
    step(0, 32'd20, 4'd0, 4'd0, 4'd0, 5'd0, 4'he);
    check("branch_in_squash_gd", {31'd0, global_disable}, 32'd0);
    check("branch_in_squash_delta", delta_instruction, 32'd0);

    step(1, 32'd8, 4'd0, 4'd8, 4'd9, 5'd6, 4'hf);
    peek(4'd9); check("lsl_r9", gpio_state, 32'h00caff00);
    peek(4'd8); check("ldr_r8", gpio_state, 32'h0000caff);
    step(0, 32'd0, 4'd8, 4'd9, 4'd0, 5'd5, 4'hf);
    step(0, 32'd4, 4'd0, 4'd0, 4'd0, 5'd0, 4'h0);
    check("beq_z0", {31'd0, global_disable}, 32'd0);

    // async reset mid-branch
    step(0, 32'd77, 4'd0, 4'd0, 4'd0, 5'd0, 4'he);
    rst_n = 1'b0;
    #1;
    check("async_gd", {31'd0, global_disable}, 32'd0);
    check("async_delta", delta_instruction, 32'd0);
    check("async_gpio", gpio_state, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    peek(4'd3); check("reset_r3", gpio_state, 32'd0);

    // random stream
    for (int i = 0; i < 3000; i++) begin
      if (i % 4 == 3) begin
        peek(4'($urandom_range(0, 15)));
      end else begin
        op  = 5'($urandom_range(0, 15));
        bc  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hf;
        ntr = 1'($urandom_range(0, 1));
        p0  = 4'($urandom_range(0, 15));
        p1  = 4'($urandom_range(0, 15));
        d   = 4'($urandom_range(0, 15));
        if ((op == 5'd9 || op == 5'd10) && $urandom_range(0, 4) != 0) begin
          ntr = 1;
          n = 32'($urandom_range(0, 35)) - m_rf[p1];
        end else if ($urandom_range(0, 1) == 0) begin
          n = 32'($urandom_range(0, 40));
        end else begin
          n = $urandom;
        end
        step(ntr, n, p0, p1, d, op, bc);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the small ARM-like pipelined CPU, sitting after Decode. Holds the 16×32 register file and the NZCV flags. Contains a 32-word data RAM with one memory-mapped GPIO register, executes one decoded micro-op per clock, and reports taken branches back to Fetch as a signed instruction delta plus a one-cycle pipeline squash.

## Interface
- No parameters.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `num_to_rhs` in 1: 1 selects `num` as the right operand R; 0 selects `reg[sel_p1]`.
- `num` in 32: immediate value, address offset, shift amount, or branch delta.
- `sel_p0` in 4: index of operand A, `reg[sel_p0]`.
- `sel_p1` in 4: index of operand B, `reg[sel_p1]`.
- `sel_in` in 4: destination register index.
- `uop` in 5: micro-op code.
- `branch_cond` in 4: ARM condition code; `4'b1111` means "not a branch".
- `global_disable` out 1: high for one cycle after a taken branch.
- `delta_instruction` out 32: signed branch offset, valid while `global_disable` is high, otherwise 0.
- `gpio_state` out 32: current GPIO register value.

## Operation
- Operands:
  - A = `reg[sel_p0]`.
  - B = `reg[sel_p1]`.
  - R = `num_to_rhs ? num : B`.
  - Register reads are combinational.
- uop table (result written to `reg[sel_in]` unless noted):
  - 0 NOP: no state change.
  - 1 ADD: A+R.
  - 2 SUB: A−R.
  - 3 AND: A&R.
  - 4 EOR: A^R.
  - 5 CMP: computes A−R and updates NZCV only; no register write.
  - 6 LSL: B << S.
  - 7 LSR: B >> S (logical).
    - S = `num_to_rhs ? num[4:0] : A[4:0]`.
  - 8 MOV: `num_to_rhs ? num : A`.
  - 9 STR: writes A to address B+R.
  - 10 LDR: `reg[sel_in]` ← mem[B+R].
  - 11 ORR: A|R.
  - 12–31: treated as NOP.
- Arithmetic is 32-bit and wraps modulo 2^32. Only CMP changes the flags.
- CMP flag rules:
  - N = result[31].
  - Z = (result == 0).
  - C = no borrow (A ≥ R, unsigned).
  - V = signed overflow of A−R.
- Address map (word addresses, using the full 32-bit sum B+R):
  - 0–31: data RAM.
  - 32: GPIO register.
  - Anything else: writes ignored, reads return 0.
- Branch instruction (`branch_cond` ≠ 1111):
  - `uop` is ignored; no register, flag or memory write.
  - The condition is evaluated against the current flags, ARM style: 0000 EQ, 0001 NE, 0010 CS, 0011 CC, 0100 MI, 0101 PL, 0110 VS, 0111 VC, 1000 HI, 1001 LS, 1010 GE, 1011 LT, 1100 GT, 1101 LE, 1110 AL.
  - Taken: the next cycle has `delta_instruction` = `num` and `global_disable` = 1.
  - Not taken: behaves as a NOP.
- While `global_disable` is high, the incoming instruction is squashed (treated as NOP). This includes a branch arriving in that cycle.
- r0–r15 are all general-purpose; r15 has no PC role inside this block.

## Timing
- Register, flag, RAM and GPIO writes occur at the rising edge ending the instruction's cycle.
- An instruction in the next cycle sees the new value (no forwarding hazard). Examples: MOV then ADD; CMP then a conditional branch.
- LDR reads RAM combinationally (asynchronous RAM read); the result is written at the same edge.
- STR to GPIO: `gpio_state` changes right after that edge. An LDR from 32 in the following cycle returns the new value.
- `global_disable` and `delta_instruction` are registered: high/valid for exactly one cycle after the taken-branch cycle, then return to 0.
- Reset (asynchronous, any time, including mid-branch):
  - All registers = 0.
  - NZCV = 0000.
  - GPIO = 0, so `gpio_state` = 0.
  - `global_disable` = 0, `delta_instruction` = 0.
  - RAM contents are not reset.
- After `rst_n` rises, the first instruction executes at the first rising edge.

## Test plan
- MOV r1,#0xCAFE; MOV r2,#0xDEAD; MOV r3,r2 (`num_to_rhs`=0, `sel_p0`=2); ADD r4=r1+r2 -> r3 = 0xDEAD, r4 = 0x1A9AB.
- AND r2 = r2 & r4 -> r2 = 0x88A9. EOR r1 = r1 ^ r3 with r1 = 0xCAFE, r3 = 0xDEAD -> r1 = 0x1453.
- MOV r6,#1; MOV r7,#1; CMP r6,r7 -> Z=1, C=1, N=0, V=0, and no register changes.
- ADD r14 = r1+r7 (0xCAFF); STR r14 to [r6+#31] -> `gpio_state` = 0xCAFF. LDR r8 from [r6+#31] -> r8 = 0xCAFF.
- Branch AL with `num`=10 -> next cycle `global_disable`=1, `delta_instruction`=10, and that cycle's instruction is squashed. The cycle after returns both outputs to 0. Branch EQ with Z=0 -> no pulse.
- LSL r9 = r8 << #8 (r8 = 0xCAFF) -> r9 = 0x00CAFF00.
- Assert `rst_n`=0 mid-sequence -> all outputs 0 immediately, without waiting for a clock edge.
